// File: rtl/rr_mux8_arbiter_pkg.sv
// rtl/rr_mux8_arbiter_pkg.sv - shared types, constants and rotating pick for rr_mux8_arbiter
package rr_mux8_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] index;
  } pick_t;

  // Walks offsets from high to low so the smallest offset from ptr is written last and wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        res.found = 1'b1;
        res.index = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// rtl/rr_mux8_arbiter_if.sv - request/data inputs and grant/mux outputs of the arbiter
interface rr_mux8_arbiter_if
  import rr_mux8_arbiter_pkg::*;
  ;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] in;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               out;

  modport master (
    output req,
    output in,
    input  grant,
    input  sel,
    input  busy,
    input  out
  );

  modport slave (
    input  req,
    input  in,
    output grant,
    output sel,
    output busy,
    output out
  );

endinterface

// File: rtl/eight_to_one_mux.sv
// rtl/eight_to_one_mux.sv - plain 8:1 single-bit mux driven by a 3-bit select
module eight_to_one_mux (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_mux8_arbiter.sv
// rtl/rr_mux8_arbiter.sv - round-robin arbiter with bounded hold driving a shared 8:1 mux
module rr_mux8_arbiter
  import rr_mux8_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  rr_mux8_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   search_base;
  pick_t              pick;
  logic               mux_out;

  // While granted, the search always starts just past the holder, so a timeout
  // prefers any other requester and falls back to the holder only if alone.
  assign search_base = (state_q == GRANT) ? sel_q + 3'd1 : ptr_q;
  assign pick        = rr_pick(bus.req, search_base);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d              = GRANT;
          grant_d              = '0;
          grant_d[pick.index]  = 1'b1;
          sel_d                = pick.index;
          ptr_d                = pick.index + 3'd1;
          cnt_d                = '0;
          busy_d               = 1'b1;
        end
      end
      GRANT: begin
        if (bus.req[sel_q] && (cnt_q < HOLD_LAST)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d = sel_q + 3'd1;
          cnt_d = '0;
          if (pick.found) begin
            grant_d             = '0;
            grant_d[pick.index] = 1'b1;
            sel_d               = pick.index;
            ptr_d               = pick.index + 3'd1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  eight_to_one_mux u_mux (
    .in  (bus.in),
    .sel (sel_q),
    .out (mux_out)
  );

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.out   = mux_out & busy_q;

endmodule
